// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Multi-cycle control unit for the 8-bit single-issue CPU. Latches the
//   instruction opcode and sequences IDLE -> EXEC -> (MEM -> LDWB | MULT)
//   states. It drives datapath mux selects, the ALU operation, register-file
//   writeback, data-memory requests and jump/branch resolution. It holds the
//   PC (STALL) while memory or multi-cycle ALU work is outstanding.
//
//   Optional feature macro: CU_MULT_EN (opcode 12 = MULT, MULT_LATENCY cycles).
//
//   Ports
//     CLK, RESET        clock, synchronous active-high reset
//     INSTR_VALID       OPCODE is valid this cycle (dropped while STALL=1)
//     OPCODE            instruction opcode (bits above [3:0] must be zero)
//     ZERO              ALU zero flag, used combinationally for PC_TAKEN
//     BUSYWAIT          data memory busy; MEM state holds while high
//     IMM, SIGN         immediate / negate mux selects
//     ALUOP             000 FWD, 001 ADD, 010 AND, 011 OR, 100 MUL
//     WRITEENABLE       register-file write
//     WB_SEL            writeback source (0 ALU, 1 memory)
//     MEMREAD/MEMWRITE  data-memory requests
//     JUMP, BRANCH      decoded j / beq
//     PC_TAKEN          JUMP | (BRANCH & ZERO)
//     STALL             hold the PC
//     ILLEGAL           undefined opcode reached EXEC
//     STATE_DBG         current FSM state (0 IDLE,1 EXEC,2 MEM,3 LDWB,4 MULT)
//
//   Handshake: an instruction is accepted on a rising edge where
//   INSTR_VALID=1 and the unit is in IDLE, or in EXEC of a single-cycle op.
//   Every other INSTR_VALID is discarded, never queued.
module multicycle_control_unit #(
  parameter int OPCODE_W     = 8,
  parameter int ALUOP_W      = 3,
  parameter int MULT_LATENCY = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                INSTR_VALID,
  input  logic [OPCODE_W-1:0] OPCODE,
  input  logic                ZERO,
  input  logic                BUSYWAIT,
  output logic                IMM,
  output logic                SIGN,
  output logic [ALUOP_W-1:0]  ALUOP,
  output logic                WRITEENABLE,
  output logic                WB_SEL,
  output logic                MEMREAD,
  output logic                MEMWRITE,
  output logic                JUMP,
  output logic                BRANCH,
  output logic                PC_TAKEN,
  output logic                STALL,
  output logic                ILLEGAL,
  output logic [2:0]          STATE_DBG
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_MEM  = 3'd2,
    ST_LDWB = 3'd3
`ifdef CU_MULT_EN
    , ST_MULT = 3'd4
`endif
  } state_t;

  localparam logic [ALUOP_W-1:0] ALU_FWD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
`ifdef CU_MULT_EN
  localparam logic [ALUOP_W-1:0] ALU_MUL = ALUOP_W'(4);
  localparam logic [3:0]         MAX_OP  = 4'd12;
  localparam int CNT_W = (MULT_LATENCY > 2) ? $clog2(MULT_LATENCY - 1) : 1;
`else
  localparam logic [3:0]         MAX_OP  = 4'd11;
`endif

  // Legal opcodes have every bit above the 4-bit field clear.
  function automatic logic op_legal(input logic [OPCODE_W-1:0] op);
    return ((op >> 4) == '0) && (op[3:0] <= MAX_OP);
  endfunction

  state_t                state_q, state_d;
  logic [OPCODE_W-1:0]   opcode_q, opcode_d;
`ifdef CU_MULT_EN
  logic [CNT_W-1:0]      cnt_q, cnt_d;
`endif
  logic                  imm_q, imm_d, sign_q, sign_d, we_q, we_d, wb_q, wb_d;
  logic                  mr_q, mr_d, mw_q, mw_d, jump_q, jump_d, br_q, br_d;
  logic                  stall_q, stall_d, ill_q, ill_d;
  logic [ALUOP_W-1:0]    aluop_q, aluop_d;
  logic [3:0]            lo_q, lo_d;

  // Next state.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
`ifdef CU_MULT_EN
    cnt_d    = cnt_q;
`endif
    lo_q     = opcode_q[3:0];
    case (state_q)
      ST_IDLE: if (INSTR_VALID) begin
        state_d  = ST_EXEC;
        opcode_d = OPCODE;
      end
      ST_EXEC: begin
        if (!op_legal(opcode_q))              state_d = ST_IDLE;
        else if (lo_q >= 4'd8 && lo_q <= 4'd11) state_d = ST_MEM;
`ifdef CU_MULT_EN
        else if (lo_q == 4'd12) begin
          state_d = ST_MULT;
          cnt_d   = CNT_W'(MULT_LATENCY - 2);
        end
`endif
        else if (INSTR_VALID) begin
          state_d  = ST_EXEC;
          opcode_d = OPCODE;
        end else                              state_d = ST_IDLE;
      end
      ST_MEM: if (!BUSYWAIT) state_d = (lo_q <= 4'd9) ? ST_LDWB : ST_IDLE;
      ST_LDWB: state_d = ST_IDLE;
`ifdef CU_MULT_EN
      ST_MULT: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered and
  // appear in the same cycle the state is entered.
  always_comb begin
    imm_d = 1'b0; sign_d = 1'b0; we_d = 1'b0; wb_d = 1'b0;
    mr_d = 1'b0; mw_d = 1'b0; jump_d = 1'b0; br_d = 1'b0;
    stall_d = 1'b0; ill_d = 1'b0; aluop_d = ALU_FWD;
    lo_d = opcode_d[3:0];
    case (state_d)
      ST_EXEC: begin
        if (!op_legal(opcode_d)) ill_d = 1'b1;
        else begin
          case (lo_d)
            4'd0: begin imm_d = 1'b1; we_d = 1'b1; end
            4'd1: we_d = 1'b1;
            4'd2: begin aluop_d = ALU_ADD; we_d = 1'b1; end
            4'd3: begin aluop_d = ALU_ADD; sign_d = 1'b1; we_d = 1'b1; end
            4'd4: begin aluop_d = ALU_AND; we_d = 1'b1; end
            4'd5: begin aluop_d = ALU_OR;  we_d = 1'b1; end
            4'd6: jump_d = 1'b1;
            4'd7: begin aluop_d = ALU_ADD; sign_d = 1'b1; br_d = 1'b1; end
            4'd8, 4'd10: stall_d = 1'b1;
            4'd9, 4'd11: begin imm_d = 1'b1; stall_d = 1'b1; end
`ifdef CU_MULT_EN
            4'd12: begin aluop_d = ALU_MUL; stall_d = 1'b1; end
`endif
            default: ill_d = 1'b1;
          endcase
        end
      end
      ST_MEM: begin
        // IMM/ALUOP stay as in EXEC so the address stays stable.
        imm_d   = (lo_d == 4'd9) || (lo_d == 4'd11);
        mr_d    = (lo_d <= 4'd9);
        mw_d    = (lo_d >= 4'd10);
        stall_d = 1'b1;
      end
      ST_LDWB: begin
        we_d = 1'b1; wb_d = 1'b1; stall_d = 1'b1;
      end
`ifdef CU_MULT_EN
      ST_MULT: begin
        aluop_d = ALU_MUL;
        // Final MULT cycle writes back and releases the PC.
        if (cnt_d == '0) we_d    = 1'b1;
        else             stall_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE; opcode_q <= '0;
`ifdef CU_MULT_EN
      cnt_q <= '0;
`endif
      imm_q <= 1'b0; sign_q <= 1'b0; we_q <= 1'b0; wb_q <= 1'b0;
      mr_q <= 1'b0; mw_q <= 1'b0; jump_q <= 1'b0; br_q <= 1'b0;
      stall_q <= 1'b0; ill_q <= 1'b0; aluop_q <= ALU_FWD;
    end else begin
      state_q <= state_d; opcode_q <= opcode_d;
`ifdef CU_MULT_EN
      cnt_q <= cnt_d;
`endif
      imm_q <= imm_d; sign_q <= sign_d; we_q <= we_d; wb_q <= wb_d;
      mr_q <= mr_d; mw_q <= mw_d; jump_q <= jump_d; br_q <= br_d;
      stall_q <= stall_d; ill_q <= ill_d; aluop_q <= aluop_d;
    end
  end

  assign IMM         = imm_q;
  assign SIGN        = sign_q;
  assign ALUOP       = aluop_q;
  assign WRITEENABLE = we_q;
  assign WB_SEL      = wb_q;
  assign MEMREAD     = mr_q;
  assign MEMWRITE    = mw_q;
  assign JUMP        = jump_q;
  assign BRANCH      = br_q;
  assign PC_TAKEN    = jump_q | (br_q & ZERO);
  assign STALL       = stall_q;
  assign ILLEGAL     = ill_q;
  assign STATE_DBG   = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit. Each table row drives the
// inputs for one clock cycle and queues the outputs expected during that
// cycle; a monitor on the falling edge pops and compares.
module tb_multicycle_control_unit;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       INSTR_VALID = 1'b0;
  logic [7:0] OPCODE = '0;
  logic       ZERO = 1'b0;
  logic       BUSYWAIT = 1'b0;
  logic       IMM, SIGN, WRITEENABLE, WB_SEL, MEMREAD, MEMWRITE;
  logic       JUMP, BRANCH, PC_TAKEN, STALL, ILLEGAL;
  logic [2:0] ALUOP, STATE_DBG;

  multicycle_control_unit dut (
    .CLK(CLK), .RESET(RESET), .INSTR_VALID(INSTR_VALID), .OPCODE(OPCODE),
    .ZERO(ZERO), .BUSYWAIT(BUSYWAIT), .IMM(IMM), .SIGN(SIGN), .ALUOP(ALUOP),
    .WRITEENABLE(WRITEENABLE), .WB_SEL(WB_SEL), .MEMREAD(MEMREAD),
    .MEMWRITE(MEMWRITE), .JUMP(JUMP), .BRANCH(BRANCH), .PC_TAKEN(PC_TAKEN),
    .STALL(STALL), .ILLEGAL(ILLEGAL), .STATE_DBG(STATE_DBG)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  localparam logic [2:0] S_IDLE = 3'd0, S_EXEC = 3'd1, S_MEM = 3'd2,
                         S_LDWB = 3'd3, S_MULT = 3'd4;

  // scoreboard
  logic [16:0] exp_q[$];
  string       name_q[$];
  int          total = 0;
  int          bad = 0;

  function automatic logic [16:0] ev(input logic [2:0] st, input logic imm,
      input logic sign, input logic [2:0] alu, input logic we, input logic wb,
      input logic mr, input logic mw, input logic j, input logic b,
      input logic pc, input logic stall, input logic ill);
    return {st, imm, sign, alu, we, wb, mr, mw, j, b, pc, stall, ill};
  endfunction

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      logic [16:0] e, act;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      act = {STATE_DBG, IMM, SIGN, ALUOP, WRITEENABLE, WB_SEL, MEMREAD,
             MEMWRITE, JUMP, BRANCH, PC_TAKEN, STALL, ILLEGAL};
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got st/imm/sign/alu/we/wb/mr/mw/j/b/pc/stall/ill=%b want %b",
                 n, act, e);
      end
    end
  end

  // driver: apply inputs for one cycle, optionally queue expectations
  task automatic cyc(input logic rst, input logic iv, input logic [7:0] op,
                     input logic z, input logic busy, input logic chk,
                     input logic [16:0] e, input string n);
    RESET = rst; INSTR_VALID = iv; OPCODE = op; ZERO = z; BUSYWAIT = busy;
    if (chk) begin
      exp_q.push_back(e);
      name_q.push_back(n);
    end
    @(posedge CLK);
    #1;
  endtask

  logic [16:0] idle_v;

  initial begin
    idle_v = ev(S_IDLE, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 8'd0, 0, 0, 0, idle_v, "");
    cyc(1, 0, 8'd0, 0, 0, 1, idle_v, "reset_state");

    // LOADI, ADD, SUB back-to-back, then MOV, AND, OR
    cyc(0, 1, 8'd0, 0, 0, 1, idle_v, "idle_before_loadi");
    cyc(0, 1, 8'd2, 0, 0, 1, ev(S_EXEC, 1, 0, 3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "loadi");
    cyc(0, 1, 8'd3, 0, 0, 1, ev(S_EXEC, 0, 0, 3'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0), "add");
    cyc(0, 1, 8'd1, 0, 0, 1, ev(S_EXEC, 0, 1, 3'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0), "sub");
    cyc(0, 1, 8'd4, 0, 0, 1, ev(S_EXEC, 0, 0, 3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "mov");
    cyc(0, 1, 8'd5, 0, 0, 1, ev(S_EXEC, 0, 0, 3'd2, 1, 0, 0, 0, 0, 0, 0, 0, 0), "and");
    cyc(0, 0, 8'd0, 0, 0, 1, ev(S_EXEC, 0, 0, 3'd3, 1, 0, 0, 0, 0, 0, 0, 0, 0), "or");
    cyc(0, 0, 8'd0, 0, 0, 1, idle_v, "idle_after_alu");

    // BEQ taken, BEQ not taken, J
    cyc(0, 1, 8'd7, 0, 0, 1, idle_v, "idle_before_beq");
    cyc(0, 1, 8'd7, 1, 0, 1, ev(S_EXEC, 0, 1, 3'd1, 0, 0, 0, 0, 0, 1, 1, 0, 0), "beq_taken");
    cyc(0, 1, 8'd6, 0, 0, 1, ev(S_EXEC, 0, 1, 3'd1, 0, 0, 0, 0, 0, 1, 0, 0, 0), "beq_not_taken");
    cyc(0, 0, 8'd0, 0, 0, 1, ev(S_EXEC, 0, 0, 3'd0, 0, 0, 0, 0, 1, 0, 1, 0, 0), "jump");
    cyc(0, 0, 8'd0, 0, 0, 1, idle_v, "idle_after_jump");

    // LWI, BUSYWAIT high for 3 MEM cycles, INSTR_VALID held (must be dropped)
    cyc(0, 1, 8'd9, 0, 0, 1, idle_v, "idle_before_lwi");
    cyc(0, 1, 8'd2, 0, 1, 1, ev(S_EXEC, 1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "lwi_exec");
    for (int i = 0; i < 4; i++)
      cyc(0, 1, 8'd2, 0, (i < 3), 1, ev(S_MEM, 1, 0, 3'd0, 0, 0, 1, 0, 0, 0, 0, 1, 0), "lwi_mem");
    cyc(0, 1, 8'd2, 0, 0, 1, ev(S_LDWB, 0, 0, 3'd0, 1, 1, 0, 0, 0, 0, 0, 1, 0), "lwi_ldwb");
    cyc(0, 0, 8'd0, 0, 0, 1, idle_v, "lwi_valid_dropped");

    // SWD with no wait, then second SWD reset mid-MEM
    cyc(0, 1, 8'd10, 0, 0, 1, idle_v, "idle_before_swd");
    cyc(0, 0, 8'd0, 0, 0, 1, ev(S_EXEC, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "swd_exec");
    cyc(0, 1, 8'd10, 0, 0, 1, ev(S_MEM, 0, 0, 3'd0, 0, 0, 0, 1, 0, 0, 0, 1, 0), "swd_mem");
    cyc(0, 1, 8'd10, 0, 0, 1, idle_v, "swd_done");
    cyc(0, 0, 8'd0, 0, 1, 1, ev(S_EXEC, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "swd2_exec");
    cyc(1, 0, 8'd0, 0, 1, 1, ev(S_MEM, 0, 0, 3'd0, 0, 0, 0, 1, 0, 0, 0, 1, 0), "swd2_mem");
    cyc(0, 0, 8'd0, 0, 1, 1, idle_v, "reset_mid_mem");

    // illegal opcode 0x3F; following INSTR_VALID is not accepted from EXEC
    cyc(0, 1, 8'h3F, 0, 0, 1, idle_v, "idle_before_illegal");
    cyc(0, 1, 8'd2, 0, 0, 1, ev(S_EXEC, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "illegal_3f");
    cyc(0, 1, 8'd12, 0, 0, 1, idle_v, "idle_after_illegal");
`ifdef CU_MULT_EN
    cyc(0, 0, 8'd0, 0, 0, 1, ev(S_EXEC, 0, 0, 3'd4, 0, 0, 0, 0, 0, 0, 0, 1, 0), "mult_c1");
    cyc(0, 1, 8'd2, 0, 0, 1, ev(S_MULT, 0, 0, 3'd4, 0, 0, 0, 0, 0, 0, 0, 1, 0), "mult_c2");
    cyc(0, 0, 8'd0, 0, 0, 1, ev(S_MULT, 0, 0, 3'd4, 0, 0, 0, 0, 0, 0, 0, 1, 0), "mult_c3");
    cyc(0, 0, 8'd0, 0, 0, 1, ev(S_MULT, 0, 0, 3'd4, 1, 0, 0, 0, 0, 0, 0, 0, 0), "mult_c4");
    cyc(0, 0, 8'd0, 0, 0, 1, idle_v, "idle_after_mult");
`else
    cyc(0, 0, 8'd0, 0, 0, 1, ev(S_EXEC, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "illegal_12");
    cyc(0, 0, 8'd0, 0, 0, 1, idle_v, "idle_after_illegal_12");
`endif

    // drain the scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
